// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: registered nested-priority interrupt controller with per-source edge/level latching
module irq_priority_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter int ID_W = $clog2(NUM_IRQ),
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               int_ack,
  input  logic               eoi,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [NUM_IRQ-1:0] pending_o,
  output logic [NUM_IRQ-1:0] in_service_o,
  output logic               any_pending
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [NUM_IRQ-1:0] irq_q, pending, in_service, set_ev, ack_vec, eoi_vec, offerable;
  logic [ID_W-1:0] cand, top;
  logic cand_v, top_v, eligible, ack_ok;
  assign offerable = pending & ~irq_mask;
  always_comb begin
    cand_v = 1'b0;
    cand = '0;
    top_v = 1'b0;
    top = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (offerable[i]) begin
        cand_v = 1'b1;
        cand = ID_W'(i);
      end
      if (in_service[i]) begin
        top_v = 1'b1;
        top = ID_W'(i);
      end
    end
  end
  // a pending source may only preempt if it outranks everything already in service
  assign eligible = cand_v & (~top_v | (cand > top));
  assign ack_ok = (state == REQ) & int_ack;
  assign ack_vec = ack_ok ? (NUM_IRQ'(1) << int_id) : '0;
  assign eoi_vec = (eoi & top_v) ? (NUM_IRQ'(1) << top) : '0;
  assign set_ev = irq_in & ((~irq_q & EDGE_MASK) | (~in_service & ~EDGE_MASK));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      irq_q <= '0;
      pending <= '0;
      in_service <= '0;
      state <= IDLE;
      int_req <= 1'b0;
      int_id <= '0;
    end else begin
      irq_q <= irq_in;
      pending <= set_ev | (pending & ~ack_vec);
      in_service <= (in_service & ~eoi_vec) | ack_vec;
      if (state == IDLE) begin
        if (eligible) begin
          state <= REQ;
          int_req <= 1'b1;
          int_id <= cand;
        end
      end else if (int_ack) begin
        state <= IDLE;
        int_req <= 1'b0;
      end
    end
  assign pending_o = pending;
  assign in_service_o = in_service;
  assign any_pending = |offerable;
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed vector bench for the nested priority interrupt controller
module tb_irq_priority_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] irq_in = '0;
  logic [7:0] irq_mask = '0;
  logic int_ack = 1'b0;
  logic eoi = 1'b0;
  logic int_req;
  logic [2:0] int_id;
  logic [7:0] pending_o, in_service_o;
  logic any_pending;
  int errors = 0;
  int checks = 0;
  irq_priority_ctrl #(.NUM_IRQ(8), .EDGE_MASK(8'h7F)) dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .irq_mask(irq_mask),
    .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_id(int_id),
    .pending_o(pending_o), .in_service_o(in_service_o), .any_pending(any_pending)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] irq;
    logic [7:0] mask;
    logic ack;
    logic eoi;
    logic req;
    logic [2:0] id;
    logic [7:0] pend;
    logic [7:0] isv;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic [7:0] irq, mask, input logic ack, e, req, input logic [2:0] id, input logic [7:0] pend, isv);
    vec_t v;
    v.irq = irq; v.mask = mask; v.ack = ack; v.eoi = e;
    v.req = req; v.id = id; v.pend = pend; v.isv = isv;
    vq.push_back(v);
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic req, input logic [2:0] id, input logic [7:0] pend, isv, input logic anyp);
    chk({tag, " int_req"}, 32'(int_req), 32'(req));
    chk({tag, " int_id"}, 32'(int_id), 32'(id));
    chk({tag, " pending"}, 32'(pending_o), 32'(pend));
    chk({tag, " in_service"}, 32'(in_service_o), 32'(isv));
    chk({tag, " any_pending"}, 32'(any_pending), 32'(anyp));
  endtask
  initial begin
    // priority, ack, eoi flow
    add(8'h24, 8'h00, 0, 0, 0, 0, 8'h24, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 5, 8'h24, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 5, 8'h04, 8'h20);
    add(8'h00, 8'h00, 0, 0, 0, 5, 8'h04, 8'h20);
    add(8'h00, 8'h00, 0, 1, 0, 5, 8'h04, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 2, 8'h04, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 2, 8'h00, 8'h04);
    add(8'h00, 8'h00, 0, 1, 0, 2, 8'h00, 8'h00);
    // preemption over source 3
    add(8'h08, 8'h00, 0, 0, 0, 2, 8'h08, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 3, 8'h08, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 3, 8'h00, 8'h08);
    add(8'h40, 8'h00, 0, 0, 0, 3, 8'h40, 8'h08);
    add(8'h00, 8'h00, 0, 0, 1, 6, 8'h40, 8'h08);
    add(8'h00, 8'h00, 1, 0, 0, 6, 8'h00, 8'h48);
    add(8'h00, 8'h00, 0, 1, 0, 6, 8'h00, 8'h08);
    // eoi and ack together
    add(8'h10, 8'h00, 0, 0, 0, 6, 8'h10, 8'h08);
    add(8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 8'h08);
    add(8'h00, 8'h00, 1, 1, 0, 4, 8'h00, 8'h10);
    add(8'h00, 8'h00, 0, 1, 0, 4, 8'h00, 8'h00);
    // new edge on the acked source re-pends it
    add(8'h02, 8'h00, 0, 0, 0, 4, 8'h02, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 1, 8'h02, 8'h00);
    add(8'h02, 8'h00, 1, 0, 0, 1, 8'h02, 8'h02);
    add(8'h00, 8'h00, 0, 0, 0, 1, 8'h02, 8'h02);
    add(8'h00, 8'h00, 0, 1, 0, 1, 8'h02, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 1, 8'h02, 8'h00);
    // offer stability, then level source 7
    add(8'h80, 8'h02, 0, 0, 1, 1, 8'h82, 8'h00);
    add(8'h80, 8'h02, 0, 0, 1, 1, 8'h82, 8'h00);
    add(8'h80, 8'h02, 1, 0, 0, 1, 8'h80, 8'h02);
    add(8'h80, 8'h00, 0, 0, 1, 7, 8'h80, 8'h02);
    add(8'h80, 8'h00, 1, 0, 0, 7, 8'h80, 8'h82);
    add(8'h80, 8'h00, 0, 0, 0, 7, 8'h80, 8'h82);
    add(8'h80, 8'h00, 0, 1, 0, 7, 8'h80, 8'h02);
    add(8'h80, 8'h00, 0, 0, 1, 7, 8'h80, 8'h02);
    add(8'h00, 8'h00, 1, 0, 0, 7, 8'h00, 8'h82);
    add(8'h00, 8'h00, 0, 1, 0, 7, 8'h00, 8'h02);
    add(8'h00, 8'h00, 0, 1, 0, 7, 8'h00, 8'h00);
    // masked pending persists, unmask offers it
    add(8'h10, 8'h10, 0, 0, 0, 7, 8'h10, 8'h00);
    add(8'h00, 8'h10, 0, 0, 0, 7, 8'h10, 8'h00);
    add(8'h00, 8'h00, 0, 0, 1, 4, 8'h10, 8'h00);
    add(8'h00, 8'h00, 1, 0, 0, 4, 8'h00, 8'h10);
    // ack in IDLE, then eoi on empty in_service
    add(8'h00, 8'h00, 1, 0, 0, 4, 8'h00, 8'h10);
    add(8'h00, 8'h00, 0, 1, 0, 4, 8'h00, 8'h00);
    add(8'h00, 8'h00, 0, 1, 0, 4, 8'h00, 8'h00);
    irq_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1 chk_all("reset_hold", 0, 0, 8'h00, 8'h00, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk_all("release+1", 0, 0, 8'hFF, 8'h00, 1);
    @(posedge clk);
    #1 chk_all("release+2", 1, 7, 8'hFF, 8'h00, 1);
    rst_n = 1'b0;
    #1 chk_all("reset_mid_req", 0, 0, 8'h00, 8'h00, 0);
    irq_in = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < vq.size(); i++) begin
      irq_in = vq[i].irq;
      irq_mask = vq[i].mask;
      int_ack = vq[i].ack;
      eoi = vq[i].eoi;
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vq[i].req, vq[i].id, vq[i].pend, vq[i].isv, |(vq[i].pend & ~vq[i].mask));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/irq_priority_ctrl.md
Name: irq_priority_ctrl

Overview:
Parametrised, registered interrupt controller and the successor to the combinational 8-input priority encoder. It latches per-source requests (edge or level, selectable per source) and masks them. It resolves fixed priority, with the highest index winning, and presents one request/ID to the CPU. An ack handshake moves the request to in-service, and end-of-interrupt retires it. Nested preemption is supported: a pending source is offered only if it outranks every in-service source. Sits between peripheral IRQ lines and the core's interrupt input.

Parameters:
NUM_IRQ, 8, number of sources, legal 2..32
ID_W, $clog2(NUM_IRQ), width of int_id (derived, not overridden)
EDGE_MASK, {NUM_IRQ{1'b0}}, bit i=1: source i rising-edge triggered; 0: level (active-high)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
irq_in  in  NUM_IRQ  raw requests, synchronous to clk
irq_mask  in  NUM_IRQ  1 = source masked (still latched, never offered)
int_ack  in  1  CPU accepts the offered int_id (valid only while int_req=1)
eoi  in  1  end of interrupt, retires highest in-service source
int_req  out  1  request to CPU
int_id  out  ID_W  index of offered source, stable while int_req=1
pending_o  out  NUM_IRQ  pending register
in_service_o  out  NUM_IRQ  in-service register
any_pending  out  1  |(pending_o & ~irq_mask)

Behaviour:
- Reset (async assert, sync release): irq_q, pending, in_service = 0; int_req=0; int_id=0; FSM=IDLE.
- irq_q <= irq_in every cycle. Edge source i: set event = irq_in[i] & ~irq_q[i]. Level source i: set event = irq_in[i] & ~in_service[i].
- pending[i] next = set_event[i] | (pending[i] & ~clear[i]), where clear[i] = ack accepted for id i. If set and clear coincide, set wins and the source re-pends.
- Candidate: highest index i with pending[i] & ~irq_mask[i]. It is eligible only if i > highest set in_service bit, or in_service==0.
- FSM IDLE: if an eligible candidate exists, go to REQ, register int_id=candidate, int_req=1.
- FSM REQ: int_req=1 and int_id held constant regardless of later mask changes, irq_in deassertion or higher arrivals. On int_ack: pending[int_id] cleared, in_service[int_id] set, int_req=0 next cycle, go to IDLE. IDLE re-evaluates the cycle after; no back-to-back offer in the ack cycle.
- int_ack while in IDLE is ignored.
- eoi: clears the highest set in_service bit. eoi with in_service==0 is ignored. eoi and ack in the same cycle are both applied: the clear uses the pre-ack in_service, then the new bit is set.
- Latency: irq_in edge at cycle t gives pending at t+1 and int_req at t+2.
- A level source held high after eoi re-pends the following cycle. An edge source needs a new rising edge.
- A masked pending bit persists. Unmasking offers it per the normal rules.
- Reset mid-REQ or mid-service clears everything immediately. Rising edges present at reset release are detected against irq_q=0.

Test Plan:
- Reset: hold rst_n=0 with irq_in=8'hFF -> all outputs 0. Release with EDGE_MASK=0 -> pending=8'hFF at +1, int_req=1 with int_id=7 at +2.
- Priority/ack: edge sources, pulse irq_in[2] and irq_in[5] together -> int_id=5. Ack -> in_service=8'h20, pending=8'h04, and no offer (2<5). eoi -> int_id=2 offered two cycles later.
- Preemption: source 3 in service, pulse irq_in[6] -> offered int_id=6. Ack -> in_service=8'h48. eoi clears bit 6 only.
- Mask: pending[4]=1 with irq_mask[4]=1 -> int_req=0, any_pending=0. Clear the mask -> int_req=1, int_id=4 on the next cycle.
- Stability: in REQ with int_id=1, raise irq_in[7] and mask source 1 -> int_id stays 1 until ack, then 7 is offered.
- Corner cases: eoi and ack in the same cycle -> old top bit cleared, new bit set. Edge event on the acked source in the ack cycle -> pending stays 1. Level source held high after eoi -> re-pends. int_ack in IDLE and eoi with empty in_service -> no state change.
